bps_seq_ctrl: RTL and testbench



---
 rtl/bps_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_bps_seq_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bps_seq_ctrl.sv
// bps_seq_ctrl: sequencer for a 4-bit borrow-propagate subtract slice.
// It computes d = a - b - bin over 4*NIBBLES bits. One slice handles one nibble per clock,
// starting with the LSB nibble. The borrow is carried between cycles in a register.
//
// Optional feature: define BPS_SAT_EN for saturating unsigned subtraction. When the final
// borrow is set, d is forced to 0. bout still reports the borrow.
//
// Ports:
//   clk    in  1  system clock, rising edge
//   rst    in  1  synchronous active-high reset
//   start  in  1  request; accepted only in the idle or done cycle
//   a, b   in  W  minuend and subtrahend, sampled on the accepting edge
//   bin    in  1  borrow-in, sampled on the accepting edge
//   busy   out 1  nibbles are being processed
//   done   out 1  one-cycle pulse when the result is valid
//   d      out W  last completed difference, held until the next completion
//   bout   out 1  final borrow-out of the last completed operation
//   zero   out 1  last completed d is zero
module bps_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] d,
  output logic                 bout,
  output logic                 zero
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    d_q, d_d;
  logic            br_q, br_d;
  logic            bout_q, bout_d;
  logic            zero_q, zero_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [3:0]      sa, sb, sdiff;
  logic [4:0]      sbr;
  logic [W-1:0]    res_full;
  logic [IdxW+1:0] shamt;

  // The slice operates on nibble idx of the latched operands.
  always_comb begin
    shamt = {idx_q, 2'b00};
    sa    = 4'(a_q >> shamt);
    sb    = 4'(b_q >> shamt);
    sbr   = '0;
    sdiff = '0;
    sbr[0] = br_q;
    for (int i = 0; i < 4; i++) begin
      sdiff[i]  = sa[i] ^ sb[i] ^ sbr[i];
      sbr[i+1]  = (~(sa[i] ^ sb[i]) & sbr[i]) | (~sa[i] & sb[i]);
    end
    // The result register with nibble idx replaced. On the final nibble this is the full
    // difference, so d can be loaded from it on the same edge.
    res_full = (res_q & ~(W'(4'hF) << shamt)) | (W'(sdiff) << shamt);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    br_d    = br_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          idx_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        res_d = res_full;
        br_d  = sbr[4];
        idx_d = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          state_d = StDone;
`ifdef BPS_SAT_EN
          d_d = sbr[4] ? '0 : res_full;
`else
          d_d = res_full;
`endif
          bout_d = sbr[4];
          zero_d = (d_d == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b1;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign d    = d_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_bps_seq_ctrl.sv
// Self-checking bench for bps_seq_ctrl (NIBBLES=4). Expected results come from plain
// wide arithmetic on the operands. Directed cases are followed by randomized operations.
module tb_bps_seq_ctrl;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout, zero;
  logic [W-1:0] d;

  int n_checks = 0;
  int n_fail   = 0;

  // Held result: d must keep this value until the next completion.
  logic [W-1:0] prev_d;

  bps_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout),
    .zero (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: unsigned wide subtraction, with optional saturation.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in,
                       output logic [W-1:0] ed, output logic eb, output logic ez);
    logic [W:0] wide;
    wide = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bv_in};
    eb   = ({1'b0, av} < ({1'b0, bv} + {{W{1'b0}}, bv_in}));
`ifdef BPS_SAT_EN
    ed   = eb ? '0 : wide[W-1:0];
`else
    ed   = wide[W-1:0];
`endif
    ez   = (ed == '0);
  endtask

  // Issue one operation from the current idle or done cycle.
  // During RUN, start is toggled randomly with junk operands; those requests must be ignored.
  // The task returns in the done cycle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in,
                        input bit noisy);
    logic [W-1:0] ed;
    logic         eb, ez;
    int           n, nb;
    model(av, bv, bv_in, ed, eb, ez);
    a = av; b = bv; bin = bv_in; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    n = 0; nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      check("d_hold_run", 32'(d), 32'(prev_d));
      if (noisy) begin
        start = 1'($urandom);
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      step();
      n++;
    end
    start = 1'b0;
    check("latency", n, NIBBLES);
    check("busy_cycles", nb, NIBBLES);
    check("busy_in_done", 32'(busy), 0);
    check("d", 32'(d), 32'(ed));
    check("bout", 32'(bout), 32'(eb));
    check("zero", 32'(zero), 32'(ez));
    prev_d = ed;
  endtask

  // Leave the done cycle with start low and confirm the pulse lasts one cycle.
  task automatic go_idle();
    start = 1'b0;
    step();
    check("done_pulse_1cyc", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
    check("d_hold_idle", 32'(d), 32'(prev_d));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_d"}, 32'(d), 0);
    check({tag, "_bout"}, 32'(bout), 0);
    check({tag, "_zero"}, 32'(zero), 1);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    prev_d = '0;
    step(); step();
    check_reset_outs("reset");
    rst = 1'b0;
    step();
    check_reset_outs("idle_after_reset");

    // Directed cases
    run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
    check("d_1234_const", 32'(d), 32'h1000);
    go_idle();
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
    go_idle();
    run_op(16'h8000, 16'h7FFF, 1'b1, 1'b0);
    check("borrow_chain_zero", 32'(zero), 1);
    go_idle();

    // A start pulse during RUN is ignored: one done pulse, with the first result.
    a = 16'h00F0; b = 16'h000F; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 16'h5555; b = 16'h1111; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        ndone++;
        check("ignored_start_d", 32'(d), 32'h00E1);
      end
      step();
    end
    check("ignored_start_ndone", ndone, 1);
    prev_d = 16'h00E1;

    // Reset two cycles into RUN aborts with no done.
    a = 16'h4321; b = 16'h1234; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outs("abort");
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      step();
    end
    check("abort_no_done", ndone, 0);
    prev_d = '0;

    // Reset and start on the same edge: the start is dropped.
    rst = 1'b1; start = 1'b1; a = 16'h0009; b = 16'h0001;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_wins_busy", 32'(busy), 0);
    step();
    check("rst_wins_busy2", 32'(busy), 0);

    // Back-to-back: the next start is given in the done cycle.
    run_op(16'h0005, 16'h0003, 1'b0, 1'b0);
    run_op(16'h0003, 16'h0005, 1'b0, 1'b0);
    go_idle();

    // Randomized operations with ignored RUN noise, random back-to-back and idle gaps.
    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op(ra, rb, 1'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 0) go_idle();
    end
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
